reset_sequencer: RTL and testbench

- Consumes the synchronized reset produced by the upstream reset synchronizer.
- Releases NUM_STAGES downstream reset domains in fixed order: stage 0 first, stage NUM_STAGES-1 last.
- Each release is separated by a programmable hold gap and gated on a per-stage ready acknowledge, such as a PLL lock or a domain-ready flag.
- Also provides a firmware-triggered soft reset that re-runs the full sequence.

---
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES active-low reset domains in index order,
// each preceded by a HOLD_CYCLES gap and gated on the previous stage's ack.
// A soft reset request accepted in DONE replays the whole sequence.
// Optional macro RESET_SEQ_TIMEOUT_EN: bounds each ack wait to ACK_TIMEOUT
// cycles, sets a sticky timeout_err and restarts the sequence from stage 0.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int MAX_CNT = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int KW      = $clog2(NUM_STAGES) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_n_q, rst_n_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;
  logic                    ack_sel;

  // State and registered outputs; rst restores the reset values on any edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLD;
      k_q     <= '0;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: hold gap, ack wait, and soft-reset restart from DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    terr_d  = terr_q;

    // Select the ack of the current stage only; later stages' acks are ignored.
    ack_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (k_q == KW'(i)) ack_sel = stage_ack[i];
    end

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (k_q == KW'(i)) rst_n_d[i] = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        // An ack wins over a timeout that falls on the same cycle.
        if (ack_sel) begin
          cnt_d = '0;
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_HOLD;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == ACK_LAST) begin
          terr_d  = 1'b1;
          rst_n_d = '0;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (soft_rst_req) begin
          rst_n_d = '0;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      default: begin
        rst_n_d = '0;
        k_d     = '0;
        cnt_d   = '0;
        state_d = S_HOLD;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_DONE);
  end

  assign stage_rst_n = rst_n_q;
  assign seq_done    = done_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NUM_STAGES=3, HOLD_CYCLES=4, ACK_TIMEOUT=8).
// Cycle 0 is the first cycle with rst=0 (or the first cycle after a soft reset
// is accepted); outputs are sampled 1ns after each rising edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst_n;
  logic       seq_done;
  logic       busy;
  logic       timeout_err;

  int vectors = 0;
  int errors  = 0;

  reset_sequencer #(
    .NUM_STAGES (3),
    .HOLD_CYCLES(4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_rst_req = 1'b0; stage_ack = 3'b000;
    step(); step();
    vectors++;
    if (stage_rst_n !== 3'b000 || seq_done !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rst_n=%b done=%b busy=%b terr=%b, want 000 0 1 0",
               stage_rst_n, seq_done, busy, timeout_err);
    end
  endtask

  // Stage k acked 2 cycles after its release: 001@4, 011@11, 111@18, DONE@21.
  task automatic test_nominal();
    logic [2:0] exp_rn;
    logic       exp_busy;
    rst = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      if (c == 6)  stage_ack[0] = 1'b1;
      if (c == 13) stage_ack[1] = 1'b1;
      if (c == 20) stage_ack[2] = 1'b1;
      exp_rn   = (c >= 18) ? 3'b111 : (c >= 11) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      exp_busy = (c < 21);
      vectors++;
      if (stage_rst_n !== exp_rn || busy !== exp_busy || seq_done !== !exp_busy) begin
        errors++;
        $display("FAIL nominal c=%0d: rst_n=%b busy=%b done=%b, want %b %b %b",
                 c, stage_rst_n, busy, seq_done, exp_rn, exp_busy, !exp_busy);
      end
      step();
    end
  endtask

  // Soft pulse in DONE; the replay must match the nominal offsets.
  task automatic test_soft_reset();
    logic [2:0] exp_rn;
    logic       exp_busy;
    vectors++;
    if (seq_done !== 1'b1) begin
      errors++;
      $display("FAIL soft_pre_done: done=%b, want 1", seq_done);
    end
    soft_rst_req = 1'b1; stage_ack = 3'b000;
    step();
    soft_rst_req = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      if (c == 6)  stage_ack[0] = 1'b1;
      if (c == 13) stage_ack[1] = 1'b1;
      if (c == 20) stage_ack[2] = 1'b1;
      exp_rn   = (c >= 18) ? 3'b111 : (c >= 11) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      exp_busy = (c < 21);
      vectors++;
      if (stage_rst_n !== exp_rn || busy !== exp_busy || seq_done !== !exp_busy) begin
        errors++;
        $display("FAIL soft_replay c=%0d: rst_n=%b busy=%b done=%b, want %b %b %b",
                 c, stage_rst_n, busy, seq_done, exp_rn, exp_busy, !exp_busy);
      end
      step();
    end
  endtask

  // Soft pulse in WAIT_ACK(1) is ignored; rst in HOLD of stage 2 restarts.
  task automatic test_requests_during_seq();
    logic [2:0] exp_rn;
    rst = 1'b1; stage_ack = 3'b000;
    step();
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c == 6)  stage_ack[0] = 1'b1;
      if (c == 14) stage_ack[1] = 1'b1;
      soft_rst_req = (c == 12);
      if (c == 16) rst = 1'b1;
      exp_rn = (c >= 11) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      vectors++;
      if (stage_rst_n !== exp_rn || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_req c=%0d: rst_n=%b busy=%b, want %b 1", c, stage_rst_n, busy, exp_rn);
      end
      step();
    end
    soft_rst_req = 1'b0;
    vectors++;
    if (stage_rst_n !== 3'b000 || busy !== 1'b1 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: rst_n=%b busy=%b done=%b, want 000 1 0", stage_rst_n, busy, seq_done);
    end
    rst = 1'b0; stage_ack = 3'b000;
    for (int c = 0; c <= 4; c++) begin
      exp_rn = (c >= 4) ? 3'b001 : 3'b000;
      vectors++;
      if (stage_rst_n !== exp_rn) begin
        errors++;
        $display("FAIL restart c=%0d: rst_n=%b, want %b", c, stage_rst_n, exp_rn);
      end
      step();
    end
  endtask

`ifndef RESET_SEQ_TIMEOUT_EN
  // ack[0] withheld 500 cycles with later acks already high.
  task automatic test_ack_gating();
    logic [2:0] exp_rn;
    logic       exp_busy;
    rst = 1'b1; stage_ack = 3'b000;
    step();
    rst = 1'b0; stage_ack = 3'b110;
    for (int c = 0; c <= 515; c++) begin
      if (c == 504) stage_ack[0] = 1'b1;
      exp_rn   = (c >= 514) ? 3'b111 : (c >= 509) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      exp_busy = (c < 515);
      vectors++;
      if (stage_rst_n !== exp_rn || busy !== exp_busy || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL ack_gate c=%0d: rst_n=%b busy=%b terr=%b, want %b %b 0",
                 c, stage_rst_n, busy, timeout_err, exp_rn, exp_busy);
      end
      step();
    end
  endtask
`else
  // ack[1] withheld: timeout at 19, retry releases stage 0 at 23.
  task automatic test_timeout();
    logic [2:0] exp_rn;
    logic       exp_terr;
    rst = 1'b1; stage_ack = 3'b000;
    step();
    rst = 1'b0;
    for (int c = 0; c <= 34; c++) begin
      if (c == 6)  stage_ack[0] = 1'b1;
      if (c == 28) stage_ack[2:1] = 2'b11;
      exp_rn = (c >= 33) ? 3'b111 : (c >= 28) ? 3'b011 : (c >= 23) ? 3'b001 :
               (c >= 19) ? 3'b000 : (c >= 11) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      exp_terr = (c >= 19);
      vectors++;
      if (stage_rst_n !== exp_rn || timeout_err !== exp_terr || seq_done !== (c >= 34)) begin
        errors++;
        $display("FAIL timeout c=%0d: rst_n=%b terr=%b done=%b, want %b %b %b",
                 c, stage_rst_n, timeout_err, seq_done, exp_rn, exp_terr, (c >= 34));
      end
      step();
    end
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    vectors++;
    if (stage_rst_n !== 3'b000 || timeout_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL terr_sticky: rst_n=%b terr=%b busy=%b, want 000 1 1", stage_rst_n, timeout_err, busy);
    end
  endtask

  // ack[1] arrives on the last timeout cycle (18): it must win.
  task automatic test_ack_timeout_tie();
    logic [2:0] exp_rn;
    rst = 1'b1; stage_ack = 3'b000;
    step();
    rst = 1'b0;
    for (int c = 0; c <= 23; c++) begin
      if (c == 6)  stage_ack[0] = 1'b1;
      if (c == 18) stage_ack[1] = 1'b1;
      exp_rn = (c >= 23) ? 3'b111 : (c >= 11) ? 3'b011 : (c >= 4) ? 3'b001 : 3'b000;
      vectors++;
      if (stage_rst_n !== exp_rn || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tie c=%0d: rst_n=%b terr=%b, want %b 0", c, stage_rst_n, timeout_err, exp_rn);
      end
      step();
    end
  endtask
`endif

  // rst and soft_rst_req together from DONE behave like rst alone.
  task automatic test_rst_soft_collide();
    rst = 1'b1; stage_ack = 3'b000;
    step();
    rst = 1'b0; stage_ack = 3'b111;
    for (int c = 0; c < 15; c++) step();
    vectors++;
    if (seq_done !== 1'b1 || stage_rst_n !== 3'b111) begin
      errors++;
      $display("FAIL fast_done: done=%b rst_n=%b, want 1 111", seq_done, stage_rst_n);
    end
    rst = 1'b1; soft_rst_req = 1'b1;
    step();
    vectors++;
    if (stage_rst_n !== 3'b000 || busy !== 1'b1 || seq_done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL collide: rst_n=%b busy=%b done=%b terr=%b, want 000 1 0 0",
               stage_rst_n, busy, seq_done, timeout_err);
    end
    rst = 1'b0; soft_rst_req = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      vectors++;
      if (stage_rst_n !== ((c >= 4) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL collide_restart c=%0d: rst_n=%b, want %b", c, stage_rst_n,
                 ((c >= 4) ? 3'b001 : 3'b000));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_soft_reset();
    test_requests_during_seq();
`ifndef RESET_SEQ_TIMEOUT_EN
    test_ack_gating();
`else
    test_timeout();
    test_ack_timeout_tie();
`endif
    test_rst_soft_collide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
